// File: rtl/polygon_vertex_buffer.sv
// Double-buffered polygon vertex store: loads a shadow bank from a vertex stream and swaps it
// to the registered active outputs at a frame boundary. Optional pad build: define VERTEX_PAD_EN.
module polygon_vertex_buffer #(
  parameter int WORLD_BITS       = 32,
  parameter int MAX_NUM_VERTICES = 32
) (
  input  logic                                    clk_in,
  input  logic                                    rst_in,
  input  logic                                    frame_start_in,
  input  logic                                    vertex_valid_in,
  output logic                                    vertex_ready_out,
  input  logic signed [WORLD_BITS-1:0]            vertex_x_in,
  input  logic signed [WORLD_BITS-1:0]            vertex_y_in,
  input  logic                                    vertex_last_in,
  output logic signed [WORLD_BITS-1:0]            xs_out [MAX_NUM_VERTICES],
  output logic signed [WORLD_BITS-1:0]            ys_out [MAX_NUM_VERTICES],
  output logic [$clog2(MAX_NUM_VERTICES+1)-1:0]   num_points_out,
  output logic                                    shape_valid_out,
  output logic                                    overflow_out,
  output logic                                    degenerate_out
);

  localparam int CW = $clog2(MAX_NUM_VERTICES + 1);
  localparam int IW = $clog2(MAX_NUM_VERTICES);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_NUM_VERTICES);
  localparam logic [CW-1:0] MIN_C = CW'(3);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    PAD     = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t                        state;
  logic                          bank_sel;
  logic                          shadow_sel;
  logic [CW-1:0]                 wr_count;
  logic [CW-1:0]                 shadow_count;
  logic [CW-1:0]                 final_count;
  logic                          accept;
`ifdef VERTEX_PAD_EN
  logic [CW-1:0]                 pad_idx;
`endif

  logic signed [WORLD_BITS-1:0]  bank_x [2][MAX_NUM_VERTICES];
  logic signed [WORLD_BITS-1:0]  bank_y [2][MAX_NUM_VERTICES];

  logic                          wr_en;
  logic [IW-1:0]                 wr_idx;
  logic signed [WORLD_BITS-1:0]  wr_x;
  logic signed [WORLD_BITS-1:0]  wr_y;

  assign shadow_sel  = ~bank_sel;
  assign accept      = vertex_valid_in && vertex_ready_out;
  assign final_count = (wr_count == MAX_C) ? MAX_C : wr_count + CW'(1);

  // Single shadow-bank write port shared by stream loading and vertex-0 padding.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    wr_x   = vertex_x_in;
    wr_y   = vertex_y_in;
    if (rst_in) begin
      case (state)
        LOAD: begin
          if (accept && (wr_count < MAX_C)) begin
            wr_en  = 1'b1;
            wr_idx = IW'(wr_count);
          end
        end
`ifdef VERTEX_PAD_EN
        PAD: begin
          if (pad_idx < MAX_C) begin
            wr_en  = 1'b1;
            wr_idx = IW'(pad_idx);
            wr_x   = bank_x[shadow_sel][0];
            wr_y   = bank_y[shadow_sel][0];
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      bank_x[shadow_sel][wr_idx] <= wr_x;
      bank_y[shadow_sel][wr_idx] <= wr_y;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state            <= LOAD;
      wr_count         <= '0;
      shadow_count     <= '0;
      bank_sel         <= 1'b0;
      vertex_ready_out <= 1'b0;
      num_points_out   <= '0;
      shape_valid_out  <= 1'b0;
      overflow_out     <= 1'b0;
      degenerate_out   <= 1'b0;
      xs_out           <= '{default: '0};
      ys_out           <= '{default: '0};
`ifdef VERTEX_PAD_EN
      pad_idx          <= '0;
`endif
    end else begin
      case (state)
        LOAD: begin
          vertex_ready_out <= 1'b1;
          if (accept) begin
            if (wr_count == MAX_C) overflow_out <= 1'b1;
            else                   wr_count     <= wr_count + CW'(1);
            if (vertex_last_in) begin
              if (final_count < MIN_C) begin
                degenerate_out <= 1'b1;
                wr_count       <= '0;
              end else begin
                shadow_count     <= final_count;
                vertex_ready_out <= 1'b0;
`ifdef VERTEX_PAD_EN
                pad_idx          <= final_count;
                state            <= PAD;
`else
                state            <= PENDING;
`endif
              end
            end
          end
        end
`ifdef VERTEX_PAD_EN
        PAD: begin
          pad_idx <= pad_idx + CW'(1);
          // A full polygon (pad_idx == MAX) still spends one idle cycle here.
          if (pad_idx >= MAX_C - CW'(1)) state <= PENDING;
        end
`endif
        PENDING: begin
          if (frame_start_in) begin
            bank_sel         <= shadow_sel;
            xs_out           <= bank_x[shadow_sel];
            ys_out           <= bank_y[shadow_sel];
            num_points_out   <= shadow_count;
            shape_valid_out  <= 1'b1;
            wr_count         <= '0;
            vertex_ready_out <= 1'b1;
            state            <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
